adc128s022_scan_ctrl: RTL and testbench
=======================================

Name: adc128s022_scan_ctrl

Overview:
- Scan sequencer for the ADC128S022 8-channel 12-bit ADC.
- Drives an external byte-wide SPI master (mode 0) through its TX byte/DV/ready and RX byte/DV handshake, and owns the ADC chip select.
- Each ADC frame is 16 SCLKs with CS held low; the result returned in frame k belongs to the channel addressed in frame k-1. The block hides this one-frame pipeline and emits tagged 12-bit samples for a masked set of channels, either one-shot or continuously.

Parameters:
- CS_SETUP_CLKS, 4: clk cycles from CS_n falling to the first TX_DV.
- CS_HOLD_CLKS, 4: clk cycles from the last RX_DV to CS_n rising.
- GAP_CLKS, 16: clk cycles with CS_n high between scans in continuous mode (minimum 1).

Ports:
- clk  in  1  system clock
- i_Rst_L  in  1  reset, asynchronous, active-low
- i_Ch_Mask  in  8  channel enable mask; bit n enables INn
- i_Start  in  1  one-cycle pulse; starts a scan
- i_Continuous  in  1  when 1, rescan automatically after each scan
- o_Busy  out  1  high from scan start until return to IDLE
- o_TX_Byte  out  8  byte to SPI master
- o_TX_DV  out  1  one-cycle TX strobe to SPI master
- i_TX_Ready  in  1  SPI master ready for a byte
- i_RX_DV  in  1  SPI master received-byte strobe
- i_RX_Byte  in  8  received byte
- o_ADC_CS_n  out  1  ADC chip select, active-low
- o_Sample_Valid  out  1  one-cycle strobe, sample valid
- o_Sample_Ch  out  3  channel number of the sample
- o_Sample_Data  out  12  conversion result
- o_Scan_Done  out  1  one-cycle strobe after CS_n rises at scan end

Behaviour:
- Reset values (asynchronous):
  - o_ADC_CS_n=1.
  - o_TX_DV=0, o_TX_Byte=0.
  - o_Busy=0, o_Sample_Valid=0, o_Sample_Ch=0, o_Sample_Data=0, o_Scan_Done=0.
  - State=IDLE.
- Reset mid-frame aborts immediately: CS_n goes high, and no sample or done strobe is produced.
- States: IDLE, CS_SETUP, SEND_HI, WAIT_HI, SEND_LO, WAIT_LO, FRAME_END, CS_HOLD, GAP.
- IDLE:
  - i_Start=1 and i_Ch_Mask!=0: latch the mask, CS_n<=0, o_Busy<=1, go to CS_SETUP.
  - i_Start with mask==0 is ignored and produces no strobe.
  - i_Start while not in IDLE is ignored.
- CS_SETUP: count CS_SETUP_CLKS cycles, then go to SEND_HI.
- Frame list: N = popcount(mask), giving N+1 frames.
  - Frame 0 addresses the lowest enabled channel.
  - Frame k (1..N-1) addresses the k-th enabled channel in ascending order.
  - Frame N (dummy) re-addresses the lowest enabled channel.
- SEND_HI:
  - Wait for i_TX_Ready=1.
  - Drive o_TX_Byte={2'b00,addr[2:0],3'b000} and pulse o_TX_DV for exactly one cycle.
  - Go to WAIT_HI.
  - o_TX_DV is never asserted while i_TX_Ready=0.
- WAIT_HI: on i_RX_DV, capture i_RX_Byte[3:0] as data[11:8] (bits [7:4] are ignored), then go to SEND_LO.
- SEND_LO: same handshake as SEND_HI with o_TX_Byte=8'h00, then go to WAIT_LO.
- WAIT_LO: on i_RX_DV, capture data[7:0], then go to FRAME_END.
- FRAME_END (one cycle):
  - Frame index 0: data is discarded.
  - Frame index k>=1: o_Sample_Valid=1, o_Sample_Ch=channel addressed in frame k-1, o_Sample_Data=the captured 12 bits.
  - Sample latency is exactly 1 clk after the second i_RX_DV.
  - If more frames remain, advance the index and go to SEND_HI. CS_n stays low across frames.
  - Otherwise go to CS_HOLD.
- CS_HOLD:
  - After CS_HOLD_CLKS cycles: CS_n<=1, pulse o_Scan_Done for 1 cycle.
  - Then: GAP if i_Continuous=1, else IDLE with o_Busy<=0.
- GAP:
  - After GAP_CLKS cycles, if i_Continuous=1 and i_Ch_Mask!=0: relatch the mask and go to CS_SETUP.
  - Otherwise go to IDLE with o_Busy<=0.
- o_Sample_Ch and o_Sample_Data hold their last values between strobes.
- i_RX_DV outside the WAIT states is ignored.
- Mask changes during a scan have no effect until the next scan start.
- Counters are sized $clog2(max param + 1), minimum 1 bit.

Test Plan:
- Mask=0x08, Start, SPI model returns 0x0A,0xBC then 0x05,0x67:
  - TX sequence is 0x18,0x00,0x18,0x00.
  - Exactly one sample: ch=3, data=0x567.
  - CS_n is low for the whole scan, and o_Scan_Done pulses once after CS_n rises.
- Mask=0x81, per-frame returns 0x0111,0x0222,0x0333:
  - TX addresses are 0x00,0x38,0x00.
  - Samples are (ch0,0x222) then (ch7,0x333).
  - Frame 0 data is never emitted.
- i_TX_Ready held low 10 cycles before each byte: o_TX_DV is asserted only in the cycle ready=1, one pulse per byte; the sample content is unchanged.
- Mask=0x00 with Start: o_Busy, CS_n and all strobes stay idle. A Start pulse mid-scan does not restart or extend the scan.
- i_Continuous=1, mask=0x03:
  - Scans repeat with CS_n high for GAP_CLKS between them.
  - After mask is changed to 0x04 mid-scan, the next scan's samples are ch2 only.
  - Dropping i_Continuous gives IDLE after the current scan.
- Assert i_Rst_L=0 during WAIT_LO: CS_n=1 asynchronously, all outputs are at reset values, and no sample is emitted. After release, a new Start runs a clean scan.

Source files
------------

// File: rtl/adc128s022_scan_ctrl.sv
// adc128s022_scan_ctrl: scans a masked set of ADC128S022 channels through a byte-wide SPI master,
// hiding the one-frame result pipeline and emitting channel-tagged 12-bit samples.
module adc128s022_scan_ctrl #(
    parameter int CS_SETUP_CLKS = 4,
    parameter int CS_HOLD_CLKS  = 4,
    parameter int GAP_CLKS      = 16
) (
    input  logic        clk,
    input  logic        i_Rst_L,
    input  logic [7:0]  i_Ch_Mask,
    input  logic        i_Start,
    input  logic        i_Continuous,
    output logic        o_Busy,
    output logic [7:0]  o_TX_Byte,
    output logic        o_TX_DV,
    input  logic        i_TX_Ready,
    input  logic        i_RX_DV,
    input  logic [7:0]  i_RX_Byte,
    output logic        o_ADC_CS_n,
    output logic        o_Sample_Valid,
    output logic [2:0]  o_Sample_Ch,
    output logic [11:0] o_Sample_Data,
    output logic        o_Scan_Done
);
    localparam int MAX_CLKS = (CS_SETUP_CLKS > CS_HOLD_CLKS)
                            ? ((CS_SETUP_CLKS > GAP_CLKS) ? CS_SETUP_CLKS : GAP_CLKS)
                            : ((CS_HOLD_CLKS > GAP_CLKS) ? CS_HOLD_CLKS : GAP_CLKS);
    localparam int CW = (MAX_CLKS < 1) ? 1 : $clog2(MAX_CLKS + 1);
    localparam logic [CW-1:0] SETUP_LAST = CW'((CS_SETUP_CLKS > 0) ? CS_SETUP_CLKS - 1 : 0);
    localparam logic [CW-1:0] HOLD_LAST  = CW'((CS_HOLD_CLKS > 0) ? CS_HOLD_CLKS - 1 : 0);
    localparam logic [CW-1:0] GAP_LAST   = CW'((GAP_CLKS > 0) ? GAP_CLKS - 1 : 0);

    typedef enum logic [3:0] {
        IDLE, CS_SETUP, SEND_HI, WAIT_HI, SEND_LO, WAIT_LO, FRAME_END, CS_HOLD, GAP
    } state_t;

    state_t        state, state_d;
    logic [CW-1:0] cnt, cnt_d;
    logic [7:0]    mask_q, mask_d, rem, rem_d;
    logic [2:0]    cur_ch, cur_d, prev_ch, prev_d, ch_d;
    logic          first, first_d, last, last_d;
    logic [3:0]    hi, hi_d;
    logic [11:0]   data_d;
    logic          cs_n_d, busy_d, valid_d, done_d, launch;
    logic [2:0]    lo_in, lo_rem, lo_mask;

    function automatic logic [2:0] lowest(input logic [7:0] m);
        lowest = 3'd0;
        for (int i = 7; i >= 0; i--)
            if (m[i]) lowest = 3'(i);
    endfunction

    assign lo_in   = lowest(i_Ch_Mask);
    assign lo_rem  = lowest(rem);
    assign lo_mask = lowest(mask_q);

    // rem holds enabled channels not yet addressed; once empty the dummy frame re-addresses the lowest
    always_comb begin
        state_d = state;
        cnt_d = cnt;
        mask_d = mask_q;
        rem_d = rem;
        cur_d = cur_ch;
        prev_d = prev_ch;
        first_d = first;
        last_d = last;
        hi_d = hi;
        cs_n_d = o_ADC_CS_n;
        busy_d = o_Busy;
        valid_d = 1'b0;
        done_d = 1'b0;
        ch_d = o_Sample_Ch;
        data_d = o_Sample_Data;
        o_TX_DV = 1'b0;
        o_TX_Byte = 8'h00;
        launch = 1'b0;
        case (state)
            IDLE: launch = i_Start && |i_Ch_Mask;
            CS_SETUP: begin
                cnt_d = cnt + 1'b1;
                if (cnt == SETUP_LAST) begin
                    cnt_d = '0;
                    state_d = SEND_HI;
                end
            end
            SEND_HI: begin
                o_TX_Byte = {2'b00, cur_ch, 3'b000};
                o_TX_DV = i_TX_Ready;
                state_d = i_TX_Ready ? WAIT_HI : SEND_HI;
            end
            WAIT_HI: if (i_RX_DV) begin
                hi_d = i_RX_Byte[3:0];
                state_d = SEND_LO;
            end
            SEND_LO: begin
                o_TX_DV = i_TX_Ready;
                state_d = i_TX_Ready ? WAIT_LO : SEND_LO;
            end
            WAIT_LO: if (i_RX_DV) begin
                valid_d = ~first;
                if (!first) begin
                    ch_d = prev_ch;
                    data_d = {hi, i_RX_Byte};
                end
                state_d = FRAME_END;
            end
            FRAME_END: begin
                if (last) begin
                    cnt_d = '0;
                    state_d = CS_HOLD;
                end else begin
                    prev_d = cur_ch;
                    first_d = 1'b0;
                    last_d = ~|rem;
                    cur_d = |rem ? lo_rem : lo_mask;
                    rem_d = rem & ~(8'd1 << lo_rem);
                    state_d = SEND_HI;
                end
            end
            CS_HOLD: begin
                cnt_d = cnt + 1'b1;
                if (cnt == HOLD_LAST) begin
                    cnt_d = '0;
                    cs_n_d = 1'b1;
                    done_d = 1'b1;
                    busy_d = i_Continuous;
                    state_d = i_Continuous ? GAP : IDLE;
                end
            end
            GAP: begin
                cnt_d = cnt + 1'b1;
                if (cnt == GAP_LAST) begin
                    cnt_d = '0;
                    launch = i_Continuous && |i_Ch_Mask;
                    busy_d = launch;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (launch) begin
            mask_d = i_Ch_Mask;
            rem_d = i_Ch_Mask & ~(8'd1 << lo_in);
            cur_d = lo_in;
            first_d = 1'b1;
            last_d = 1'b0;
            cnt_d = '0;
            cs_n_d = 1'b0;
            busy_d = 1'b1;
            state_d = CS_SETUP;
        end
    end

    always_ff @(posedge clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            state <= IDLE;
            cnt <= '0;
            mask_q <= '0;
            rem <= '0;
            cur_ch <= '0;
            prev_ch <= '0;
            first <= 1'b0;
            last <= 1'b0;
            hi <= '0;
            o_ADC_CS_n <= 1'b1;
            o_Busy <= 1'b0;
            o_Sample_Valid <= 1'b0;
            o_Sample_Ch <= '0;
            o_Sample_Data <= '0;
            o_Scan_Done <= 1'b0;
        end else begin
            state <= state_d;
            cnt <= cnt_d;
            mask_q <= mask_d;
            rem <= rem_d;
            cur_ch <= cur_d;
            prev_ch <= prev_d;
            first <= first_d;
            last <= last_d;
            hi <= hi_d;
            o_ADC_CS_n <= cs_n_d;
            o_Busy <= busy_d;
            o_Sample_Valid <= valid_d;
            o_Sample_Ch <= ch_d;
            o_Sample_Data <= data_d;
            o_Scan_Done <= done_d;
        end
    end
endmodule

// File: tb/tb_adc128s022_scan_ctrl.sv
// tb_adc128s022_scan_ctrl: table-driven scans against a behavioural SPI master/ADC model,
// with a sample scoreboard plus hand sequences for continuous mode, ignored starts and reset.
module tb_adc128s022_scan_ctrl;
    logic        clk = 1'b0;
    logic        i_Rst_L, i_Start, i_Continuous, i_TX_Ready, i_RX_DV;
    logic [7:0]  i_Ch_Mask, i_RX_Byte, o_TX_Byte;
    logic        o_Busy, o_TX_DV, o_ADC_CS_n, o_Sample_Valid, o_Scan_Done;
    logic [2:0]  o_Sample_Ch;
    logic [11:0] o_Sample_Data;

    typedef struct packed {
        logic [7:0]  mask;
        logic [7:0]  stall;
        logic [3:0]  n_samp;
        logic [2:0]  ch0;
        logic [11:0] d0;
    } vec_t;

    vec_t        tbl [5];
    logic [15:0] resp_tbl [5][9];
    logic [7:0]  tx_log[$], rx_q[$], exp_tx[$];
    logic [14:0] exp_q[$];
    int n_tests = 0, n_fail = 0, cyc = 0, rx_cyc = 0, stall = 0;
    int dv_cnt = 0, samp_cnt = 0, done_cnt = 0, cs_falls = 0, busy_cnt = 0, hi_run = 0, last_hi_run = 0;
    logic prev_cs = 1'b1;
    logic [2:0]  first_ch = '0;
    logic [11:0] first_d = '0;

    adc128s022_scan_ctrl dut (
        .clk(clk), .i_Rst_L(i_Rst_L), .i_Ch_Mask(i_Ch_Mask), .i_Start(i_Start),
        .i_Continuous(i_Continuous), .o_Busy(o_Busy), .o_TX_Byte(o_TX_Byte), .o_TX_DV(o_TX_DV),
        .i_TX_Ready(i_TX_Ready), .i_RX_DV(i_RX_DV), .i_RX_Byte(i_RX_Byte), .o_ADC_CS_n(o_ADC_CS_n),
        .o_Sample_Valid(o_Sample_Valid), .o_Sample_Ch(o_Sample_Ch), .o_Sample_Data(o_Sample_Data),
        .o_Scan_Done(o_Scan_Done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // SPI master + ADC model: takes a byte on TX_DV, drops ready, returns the next queued byte 3 clks later
    initial begin
        i_TX_Ready = 1'b1;
        i_RX_DV = 1'b0;
        i_RX_Byte = 8'h00;
        forever begin
            #1;
            if (o_TX_DV) begin
                tx_log.push_back(o_TX_Byte);
                @(negedge clk);
                i_TX_Ready = 1'b0;
                repeat (2) @(negedge clk);
                i_RX_Byte = (rx_q.size() > 0) ? rx_q.pop_front() : 8'h00;
                i_RX_DV = 1'b1;
                rx_cyc = cyc + 1;
                @(negedge clk);
                i_RX_DV = 1'b0;
                repeat (stall) @(negedge clk);
                i_TX_Ready = 1'b1;
            end else @(negedge clk);
        end
    end

    // output monitor, sampled mid-low-phase
    initial forever begin
        logic [14:0] e;
        @(negedge clk);
        #2;
        if (o_TX_DV) begin
            dv_cnt++;
            if (!i_TX_Ready) chk("tx_dv_without_ready", 1, 0);
            if (o_ADC_CS_n) chk("cs_low_at_tx", 1, 0);
        end
        if (o_Busy) busy_cnt++;
        if (o_Sample_Valid) begin
            samp_cnt++;
            if (samp_cnt == 1) begin
                first_ch = o_Sample_Ch;
                first_d = o_Sample_Data;
            end
            chk("sample_latency", cyc, rx_cyc);
            if (exp_q.size() == 0) chk("unexpected_sample", 1, 0);
            else begin
                e = exp_q.pop_front();
                chk("sample_ch", o_Sample_Ch, e[14:12]);
                chk("sample_data", o_Sample_Data, e[11:0]);
            end
        end
        if (o_Scan_Done) begin
            done_cnt++;
            chk("done_cs_high", o_ADC_CS_n, 1);
        end
        if (o_ADC_CS_n) hi_run++;
        else begin
            if (hi_run > 0) last_hi_run = hi_run;
            hi_run = 0;
        end
        if (prev_cs && !o_ADC_CS_n) cs_falls++;
        prev_cs = o_ADC_CS_n;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic plan(input logic [7:0] m, input logic [15:0] w [9], output int nf);
        int chs[$];
        for (int c = 0; c < 8; c++) if (m[c]) chs.push_back(c);
        chs.push_back(chs[0]);
        nf = chs.size();
        for (int f = 0; f < nf; f++) begin
            exp_tx.push_back({2'b00, 3'(chs[f]), 3'b000});
            exp_tx.push_back(8'h00);
            rx_q.push_back(w[f][15:8]);
            rx_q.push_back(w[f][7:0]);
            if (f > 0) exp_q.push_back({3'(chs[f-1]), w[f][11:0]});
        end
    endtask

    task automatic clear_counts();
        tx_log.delete();
        dv_cnt = 0;
        samp_cnt = 0;
        done_cnt = 0;
        cs_falls = 0;
        busy_cnt = 0;
    endtask

    task automatic check_tx(input string name);
        chk({name, "_tx_count"}, tx_log.size(), exp_tx.size());
        for (int i = 0; i < tx_log.size() && i < exp_tx.size(); i++)
            chk({name, "_tx_byte"}, tx_log[i], exp_tx[i]);
        exp_tx.delete();
    endtask

    task automatic pulse_start(input logic [7:0] m);
        @(negedge clk);
        i_Ch_Mask = m;
        i_Start = 1'b1;
        @(negedge clk);
        i_Start = 1'b0;
    endtask

    task automatic run_scan(input int idx, input logic mid_start);
        vec_t v;
        int nf;
        v = tbl[idx];
        clear_counts();
        stall = int'(v.stall);
        plan(v.mask, resp_tbl[idx], nf);
        pulse_start(v.mask);
        if (mid_start) begin
            for (int i = 0; i < 500 && tx_log.size() < 2; i++) @(posedge clk);
            pulse_start(8'h81);
        end
        for (int i = 0; i < 3000 && done_cnt == 0; i++) @(posedge clk);
        chk("scan_finished", done_cnt, 1);
        repeat (10) @(negedge clk);
        chk("busy_after_scan", o_Busy, 0);
        chk("cs_after_scan", o_ADC_CS_n, 1);
        chk("done_pulses", done_cnt, 1);
        chk("cs_falls", cs_falls, 1);
        chk("n_samples", samp_cnt, v.n_samp);
        chk("first_ch", first_ch, v.ch0);
        chk("first_data", first_d, v.d0);
        chk("dv_pulses", dv_cnt, 2 * nf);
        chk("scoreboard_empty", exp_q.size(), 0);
        check_tx("scan");
    endtask

    initial begin
        logic [15:0] wa [9], wb [9], wc [9];
        int nf;
        i_Rst_L = 1'b0;
        i_Start = 1'b0;
        i_Continuous = 1'b0;
        i_Ch_Mask = 8'h00;
        tbl = '{
            '{8'h08, 8'd0,  4'd1, 3'd3, 12'h567},
            '{8'h81, 8'd0,  4'd2, 3'd0, 12'h222},
            '{8'h08, 8'd10, 4'd1, 3'd3, 12'h567},
            '{8'hFF, 8'd1,  4'd8, 3'd0, 12'h001},
            '{8'h24, 8'd2,  4'd2, 3'd2, 12'hBBB}
        };
        resp_tbl = '{
            '{16'h0ABC, 16'h0567, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0},
            '{16'h0111, 16'h0222, 16'h0333, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0},
            '{16'h0ABC, 16'h0567, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0},
            '{16'h1000, 16'hF001, 16'hA7FF, 16'h5123, 16'hC456, 16'h3789, 16'h9ABC, 16'h6DEF, 16'h2FED},
            '{16'h0AAA, 16'h0BBB, 16'h0CCC, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0}
        };
        repeat (3) @(negedge clk);
        chk("rst_cs_n", o_ADC_CS_n, 1);
        chk("rst_busy", o_Busy, 0);
        chk("rst_tx_dv", o_TX_DV, 0);
        chk("rst_tx_byte", o_TX_Byte, 0);
        chk("rst_valid", o_Sample_Valid, 0);
        chk("rst_done", o_Scan_Done, 0);
        i_Rst_L = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 5; i++) run_scan(i, 1'b0);

        // empty mask: start is ignored
        clear_counts();
        pulse_start(8'h00);
        repeat (30) @(negedge clk);
        chk("mask0_busy", busy_cnt, 0);
        chk("mask0_cs_falls", cs_falls, 0);
        chk("mask0_done", done_cnt, 0);
        chk("mask0_samples", samp_cnt, 0);
        chk("mask0_tx", dv_cnt, 0);

        // second start mid-scan neither restarts nor extends the scan
        run_scan(0, 1'b1);

        // continuous: two 0x03 scans, mask switched to 0x04 during the second, continuous dropped in the third
        clear_counts();
        stall = 0;
        for (int f = 0; f < 9; f++) begin
            wa[f] = 16'h0100 + 16'(f) * 16'h0111;
            wb[f] = 16'hF0A0 + 16'(f) * 16'h0101;
            wc[f] = 16'h0555 + 16'(f) * 16'h0111;
        end
        plan(8'h03, wa, nf);
        plan(8'h03, wb, nf);
        plan(8'h04, wc, nf);
        @(negedge clk);
        i_Continuous = 1'b1;
        pulse_start(8'h03);
        for (int i = 0; i < 3000 && cs_falls < 2; i++) @(posedge clk);
        chk("cont_second_scan", cs_falls, 2);
        chk("cont_gap_cycles", last_hi_run, 16);
        @(negedge clk);
        i_Ch_Mask = 8'h04;
        for (int i = 0; i < 3000 && cs_falls < 3; i++) @(posedge clk);
        chk("cont_third_scan", cs_falls, 3);
        @(negedge clk);
        i_Continuous = 1'b0;
        for (int i = 0; i < 3000 && done_cnt < 3; i++) @(posedge clk);
        chk("cont_done", done_cnt, 3);
        repeat (40) @(negedge clk);
        chk("cont_idle_busy", o_Busy, 0);
        chk("cont_no_rescan", cs_falls, 3);
        chk("cont_samples", samp_cnt, 5);
        chk("cont_scoreboard_empty", exp_q.size(), 0);
        check_tx("cont");

        // asynchronous reset during WAIT_LO of the final frame
        clear_counts();
        rx_q.delete();
        for (int i = 0; i < 4; i++) rx_q.push_back(i[0] ? 8'hBC : 8'h0A);
        pulse_start(8'h08);
        for (int i = 0; i < 500 && tx_log.size() < 4; i++) @(posedge clk);
        chk("rst_reached_wait_lo", tx_log.size(), 4);
        @(negedge clk);
        #3 i_Rst_L = 1'b0;
        #1;
        chk("arst_cs_n", o_ADC_CS_n, 1);
        chk("arst_busy", o_Busy, 0);
        chk("arst_tx_dv", o_TX_DV, 0);
        chk("arst_tx_byte", o_TX_Byte, 0);
        chk("arst_valid", o_Sample_Valid, 0);
        chk("arst_ch", o_Sample_Ch, 0);
        chk("arst_data", o_Sample_Data, 0);
        chk("arst_done", o_Scan_Done, 0);
        repeat (20) @(negedge clk);
        i_Rst_L = 1'b1;
        repeat (5) @(negedge clk);
        chk("arst_no_sample", samp_cnt, 0);
        chk("arst_no_done", done_cnt, 0);
        rx_q.delete();
        exp_tx.delete();
        run_scan(1, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
